// File: rtl/cvxif_instr_pkg.sv
// rtl/cvxif_instr_pkg.sv - shared types for the CV-X-IF issue initiator
package cvxif_instr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic [31:0] instr;
  } issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
  } issue_resp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } result_t;

  typedef struct packed {
    logic valid;
    logic wb;
  } id_entry_t;

  // A result only needs the register-file port when its entry is live and expects a write.
  function automatic logic needs_wb(input id_entry_t e, input logic we);
    return e.valid && e.wb && we;
  endfunction

endpackage

// File: rtl/cvxif_id_table.sv
// rtl/cvxif_id_table.sv - outstanding-id table with lowest-free allocation
module cvxif_id_table
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned IdWidth = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_en,
  input  logic [IdWidth-1:0] alloc_id,
  input  logic               alloc_wb,
  input  logic               free_en,
  input  logic [IdWidth-1:0] free_id,
  input  logic [IdWidth-1:0] lookup_id,
  output id_entry_t          lookup,
  output logic [IdWidth-1:0] lowest_free,
  output logic               full
);

  localparam int Depth = 1 << IdWidth;

  id_entry_t [Depth-1:0] entries_q;

  // Alloc and free never target the same id: only an invalid entry is allocated.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
    end else begin
      if (free_en) begin
        entries_q[free_id].valid <= 1'b0;
      end
      if (alloc_en) begin
        entries_q[alloc_id].valid <= 1'b1;
        entries_q[alloc_id].wb    <= alloc_wb;
      end
    end
  end

  always_comb begin
    lowest_free = '0;
    full        = 1'b1;
    for (int i = Depth - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        lowest_free = IdWidth'(i);
        full        = 1'b0;
      end
    end
  end

  assign lookup = entries_q[lookup_id];

endmodule

// File: rtl/cvxif_issue_initiator.sv
// rtl/cvxif_issue_initiator.sv - offloads core instructions over CV-X-IF and routes results
module cvxif_issue_initiator
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned IdWidth   = 2,
  parameter int unsigned NrRsPorts = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       instr_valid_i,
  input  logic [31:0]                instr_i,
  input  logic [NrRsPorts-1:0][31:0] rs_i,
  output logic                       instr_ready_o,
  output logic                       issue_valid_o,
  output logic [31:0]                issue_instr_o,
  output logic [IdWidth-1:0]         issue_id_o,
  output logic [NrRsPorts-1:0][31:0] issue_rs_o,
  input  logic                       issue_ready_i,
  input  logic                       issue_accept_i,
  input  logic                       issue_writeback_i,
  input  logic [NrRsPorts-1:0]       issue_register_read_i,
  output logic                       accepted_o,
  output logic                       illegal_o,
  output logic [IdWidth-1:0]         accepted_id_o,
  input  logic                       result_valid_i,
  output logic                       result_ready_o,
  input  logic [IdWidth-1:0]         result_id_i,
  input  logic [31:0]                result_data_i,
  input  logic [4:0]                 result_rd_i,
  input  logic                       result_we_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [4:0]                 wb_rd_o,
  output logic [31:0]                wb_data_o,
  output logic                       protocol_err_o
);

  issue_state_e               state_q, state_d;
  issue_req_t                 req_q;
  logic [NrRsPorts-1:0][31:0] rs_q;
  logic [IdWidth-1:0]         id_q;
  logic [IdWidth-1:0]         lowest_free;
  logic                       table_full;
  logic                       capture, alloc_en, accept_pulse, illegal_pulse;
  logic                       need_wb, free_en;
  id_entry_t                  res_entry;
  issue_resp_t                resp;
  result_t                    res;

  assign resp = '{accept: issue_accept_i, writeback: issue_writeback_i};
  assign res  = '{data: result_data_i, rd: result_rd_i, we: result_we_i};

  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    alloc_en      = 1'b0;
    accept_pulse  = 1'b0;
    illegal_pulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid_i && instr_ready_o) begin
          capture = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A rejected instruction never enters the table, so its id is free again.
        if (issue_ready_i) begin
          accept_pulse  = resp.accept;
          alloc_en      = resp.accept;
          illegal_pulse = !resp.accept;
          state_d       = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rs_q    <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        req_q.instr <= instr_i;
        rs_q        <= rs_i;
        id_q        <= lowest_free;
      end
    end
  end

  cvxif_id_table #(
    .IdWidth(IdWidth)
  ) u_id_table (
    .clk        (clk_i),
    .rst        (rst_i),
    .alloc_en   (alloc_en),
    .alloc_id   (id_q),
    .alloc_wb   (resp.writeback),
    .free_en    (free_en),
    .free_id    (result_id_i),
    .lookup_id  (result_id_i),
    .lookup     (res_entry),
    .lowest_free(lowest_free),
    .full       (table_full)
  );

  assign instr_ready_o = (state_q == ST_IDLE) && !table_full;
  assign issue_valid_o = (state_q == ST_REQ);
  assign issue_instr_o = req_q.instr;
  assign issue_id_o    = id_q;
  assign issue_rs_o    = rs_q;

  assign accepted_o    = accept_pulse && !rst_i;
  assign illegal_o     = illegal_pulse && !rst_i;
  assign accepted_id_o = accepted_o ? id_q : '0;

  // Results for stale ids are always consumed so a misbehaving coprocessor cannot stall us.
  assign need_wb        = needs_wb(res_entry, res.we);
  assign result_ready_o = !need_wb || wb_ready_i;
  assign free_en        = result_valid_i && result_ready_o && res_entry.valid;
  assign wb_valid_o     = result_valid_i && need_wb && !rst_i;
  assign wb_rd_o        = wb_valid_o ? res.rd : '0;
  assign wb_data_o      = wb_valid_o ? res.data : '0;
  assign protocol_err_o = result_valid_i && !res_entry.valid && !rst_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i && issue_valid_o && issue_ready_i && !issue_accept_i) begin
      assert (issue_register_read_i == '0);
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    (issue_valid_o && !issue_ready_i) |=>
      (issue_valid_o && $stable(issue_instr_o) && $stable(issue_id_o) && $stable(issue_rs_o)));

endmodule

// File: tb/tb_cvxif_issue_initiator.sv
// tb/tb_cvxif_issue_initiator.sv - scoreboard bench for cvxif_issue_initiator
module tb_cvxif_issue_initiator;

  typedef struct packed {
    logic       acc;
    logic       ill;
    logic [1:0] id;
  } out_t;

  typedef struct packed {
    logic [1:0]  kind;   // 01 write-back, 10 protocol error
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             instr_valid = 1'b0;
  logic [31:0]      instr = '0;
  logic [2:0][31:0] rs_in = '0;
  logic             instr_ready_o;
  logic             issue_valid_o;
  logic [31:0]      issue_instr_o;
  logic [1:0]       issue_id_o;
  logic [2:0][31:0] issue_rs_o;
  logic             issue_ready = 1'b0;
  logic             issue_accept = 1'b0;
  logic             issue_writeback = 1'b0;
  logic [2:0]       issue_register_read = '0;
  logic             accepted_o, illegal_o;
  logic [1:0]       accepted_id_o;
  logic             result_valid = 1'b0;
  logic             result_ready_o;
  logic [1:0]       result_id = '0;
  logic [31:0]      result_data = '0;
  logic [4:0]       result_rd = '0;
  logic             result_we = 1'b0;
  logic             wb_valid_o;
  logic             wb_ready = 1'b1;
  logic [4:0]       wb_rd_o;
  logic [31:0]      wb_data_o;
  logic             protocol_err_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mv[4];
  bit   mw[4];
  out_t oq[$];
  res_t rq[$];
  out_t mo;
  res_t mr;

  always #5 clk = ~clk;

  cvxif_issue_initiator dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .instr_valid_i        (instr_valid),
    .instr_i              (instr),
    .rs_i                 (rs_in),
    .instr_ready_o        (instr_ready_o),
    .issue_valid_o        (issue_valid_o),
    .issue_instr_o        (issue_instr_o),
    .issue_id_o           (issue_id_o),
    .issue_rs_o           (issue_rs_o),
    .issue_ready_i        (issue_ready),
    .issue_accept_i       (issue_accept),
    .issue_writeback_i    (issue_writeback),
    .issue_register_read_i(issue_register_read),
    .accepted_o           (accepted_o),
    .illegal_o            (illegal_o),
    .accepted_id_o        (accepted_id_o),
    .result_valid_i       (result_valid),
    .result_ready_o       (result_ready_o),
    .result_id_i          (result_id),
    .result_data_i        (result_data),
    .result_rd_i          (result_rd),
    .result_we_i          (result_we),
    .wb_valid_o           (wb_valid_o),
    .wb_ready_i           (wb_ready),
    .wb_rd_o              (wb_rd_o),
    .wb_data_o            (wb_data_o),
    .protocol_err_o       (protocol_err_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++) begin
      if (!mv[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (accepted_o || illegal_o) begin
        if (oq.size() == 0) begin
          check("outcome_unexpected", {accepted_o, illegal_o}, 2'b00);
        end else begin
          mo = oq.pop_front();
          check("outcome_kind", {accepted_o, illegal_o}, {mo.acc, mo.ill});
          check("accepted_id", accepted_id_o, mo.acc ? mo.id : 2'b00);
        end
      end
      if ((wb_valid_o && wb_ready) || protocol_err_o) begin
        if (rq.size() == 0) begin
          check("result_unexpected", {protocol_err_o, wb_valid_o}, 2'b00);
        end else begin
          mr = rq.pop_front();
          check("result_kind", {protocol_err_o, wb_valid_o && wb_ready}, mr.kind);
          if (mr.kind == 2'b01) begin
            check("wb_rd", wb_rd_o, mr.rd);
            check("wb_data", wb_data_o, mr.data);
          end
        end
      end
    end
  end

  task automatic do_issue(input logic [31:0] ins, input bit acc, input bit wb,
                          input int stall, input int co_free);
    int          n;
    int          eid;
    logic [95:0] rs;
    out_t        o;
    n = 0;
    @(negedge clk);
    while (!instr_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("instr_ready_wait", instr_ready_o, 1'b1);
    #1;
    eid = lowest_free();
    rs = {$urandom, $urandom, $urandom};
    instr_valid = 1'b1;
    instr = ins;
    rs_in = rs;
    tick();
    instr_valid = 1'b0;
    instr = '0;
    rs_in = '0;
    for (int c = 0; c <= stall; c++) begin
      if (c == stall) begin
        issue_ready = 1'b1;
        issue_accept = acc;
        issue_writeback = wb;
        issue_register_read = acc ? 3'b111 : 3'b000;
        o.acc = acc;
        o.ill = !acc;
        o.id = eid[1:0];
        oq.push_back(o);
        if (co_free >= 0) begin
          result_valid = 1'b1;
          result_id = co_free[1:0];
          result_we = 1'b0;
          result_rd = 5'd9;
          result_data = 32'h0BAD_F00D;
        end
      end
      @(negedge clk);
      check("issue_valid", issue_valid_o, 1'b1);
      check("issue_instr", issue_instr_o, ins);
      check("issue_id", issue_id_o, eid[1:0]);
      check("issue_rs", issue_rs_o, rs);
      tick();
    end
    if (co_free >= 0) mv[co_free] = 1'b0;
    if (acc) begin
      mv[eid] = 1'b1;
      mw[eid] = wb;
    end
    issue_ready = 1'b0;
    issue_accept = 1'b0;
    issue_writeback = 1'b0;
    issue_register_read = '0;
    result_valid = 1'b0;
  endtask

  task automatic do_result(input int id, input logic [31:0] data, input logic [4:0] rd,
                           input bit we, input int hold);
    int   n;
    res_t r;
    if (mv[id] && mw[id] && we) begin
      r.kind = 2'b01;
      r.rd = rd;
      r.data = data;
      rq.push_back(r);
    end else if (!mv[id]) begin
      r.kind = 2'b10;
      r.rd = '0;
      r.data = '0;
      rq.push_back(r);
    end
    result_valid = 1'b1;
    result_id = id[1:0];
    result_data = data;
    result_rd = rd;
    result_we = we;
    wb_ready = (hold == 0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check("result_ready_hold", result_ready_o, 1'b0);
      check("wb_valid_hold", wb_valid_o, 1'b1);
      tick();
    end
    wb_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!result_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("result_ready", result_ready_o, 1'b1);
    tick();
    result_valid = 1'b0;
    result_we = 1'b0;
    mv[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    result_valid = 1'b1;
    result_id = 2'd3;
    result_we = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_issue_valid", issue_valid_o, 1'b0);
    check("rst_issue_instr", issue_instr_o, 32'h0);
    check("rst_issue_id", issue_id_o, 2'd0);
    check("rst_accepted", accepted_o, 1'b0);
    check("rst_illegal", illegal_o, 1'b0);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_protocol_err", protocol_err_o, 1'b0);
    check("rst_instr_ready", instr_ready_o, 1'b1);
    check("rst_result_ready", result_ready_o, 1'b1);
    result_valid = 1'b0;
    result_we = 1'b0;
    tick();
    rst = 1'b0;

    do_issue(32'h0000_002B, 1'b1, 1'b1, 0, -1);
    do_result(0, 32'hDEAD_BEEF, 5'd5, 1'b1, 0);

    do_issue(32'h0000_0033, 1'b0, 1'b1, 0, -1);
    do_issue(32'h0000_0077, 1'b1, 1'b0, 0, -1);
    do_result(0, 32'h1111_0000, 5'd1, 1'b1, 0);

    for (int k = 0; k < 4; k++) begin
      do_issue(32'h0000_1000 + k, 1'b1, 1'b1, k % 2, -1);
    end
    @(negedge clk);
    check("full_instr_ready", instr_ready_o, 1'b0);
    tick();
    do_result(2, 32'h2222_2222, 5'd7, 1'b1, 0);
    @(negedge clk);
    check("freed_instr_ready", instr_ready_o, 1'b1);
    tick();
    do_issue(32'h0000_2002, 1'b1, 1'b1, 0, -1);
    do_result(0, 32'h3000_0000, 5'd3, 1'b0, 0);
    do_result(1, 32'h3000_0001, 5'd31, 1'b1, 0);
    do_result(2, 32'h3000_0002, 5'd0, 1'b1, 0);
    do_result(3, 32'hFFFF_FFFF, 5'd17, 1'b1, 0);

    do_issue(32'hABCD_0123, 1'b1, 1'b0, 3, -1);
    do_issue(32'h0000_0555, 1'b1, 1'b1, 1, 0);
    do_result(0, 32'h4444_0000, 5'd4, 1'b1, 0);
    do_result(1, 32'h4444_0001, 5'd8, 1'b1, 0);
    do_result(3, 32'h5555_5555, 5'd2, 1'b1, 0);

    do_issue(32'h0000_0666, 1'b1, 1'b1, 0, -1);
    do_result(0, 32'hCAFE_0001, 5'd12, 1'b1, 3);

    @(negedge clk);
    #1;
    instr_valid = 1'b1;
    instr = 32'h1234_5678;
    rs_in = {32'h1, 32'h2, 32'h3};
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    check("req_before_rst", issue_valid_o, 1'b1);
    #1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid_req_valid", issue_valid_o, 1'b0);
    check("rst_mid_req_instr", issue_instr_o, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;

    do_issue(32'h0000_0888, 1'b1, 1'b0, 0, -1);
    do_result(0, 32'h6666_6666, 5'd6, 1'b1, 0);

    repeat (3) @(negedge clk);
    check("outcome_q_empty", oq.size(), 0);
    check("result_q_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cvxif_issue_initiator.md
CVXIF_ISSUE_INITIATOR -- requirements
Module: cvxif_issue_initiator

Interface
REQ-001 SHALL have parameter IdWidth, default 2, giving the transaction-id width; the outstanding table holds 2**IdWidth entries.
REQ-002 SHALL have parameter NrRsPorts, default 3, giving the number of source-operand ports, matching the register_read width.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports instr_valid_i in 1, instr_i in 32, rs_i in NrRsPorts x 32, instr_ready_o out 1: the core-side offload request.
REQ-006 SHALL have ports issue_valid_o out 1, issue_instr_o out 32, issue_id_o out IdWidth, issue_rs_o out NrRsPorts x 32: the issue request to the coprocessor.
REQ-007 SHALL have ports issue_ready_i in 1, issue_accept_i in 1, issue_writeback_i in 1, issue_register_read_i in NrRsPorts: the issue response.
REQ-008 SHALL have ports accepted_o out 1, illegal_o out 1, accepted_id_o out IdWidth: the one-cycle outcome pulse to the core.
REQ-009 SHALL have ports result_valid_i in 1, result_ready_o out 1, result_id_i in IdWidth, result_data_i in 32, result_rd_i in 5, result_we_i in 1: the result channel.
REQ-010 SHALL have ports wb_valid_o out 1, wb_ready_i in 1, wb_rd_o out 5, wb_data_o out 32, protocol_err_o out 1: the register-file write and error flag.

Function
REQ-011 SHALL implement the FSM IDLE -> REQ -> IDLE.
REQ-012 SHALL drive instr_ready_o = (state==IDLE) && (at least one free table entry).
REQ-013 SHALL, on instr_valid_i && instr_ready_o: capture instr_i and rs_i, assign the lowest free id, and enter REQ.
REQ-014 SHALL, in REQ: hold issue_valid_o=1; issue_instr_o, issue_id_o and issue_rs_o SHALL be held stable until issue_ready_i; valid SHALL never be retracted before the handshake.
REQ-015 SHALL, on REQ && issue_ready_i && issue_accept_i: set table[id].valid=1 and table[id].wb=issue_writeback_i, pulse accepted_o=1 with accepted_id_o=id for one cycle, and return to IDLE.
REQ-016 SHALL, on REQ && issue_ready_i && !issue_accept_i: pulse illegal_o for one cycle, leave the table unchanged, free the id, and return to IDLE.
REQ-017 SHALL ignore issue_register_read_i for operand timing (all operands are valid at capture); it is sampled for assertions only.
REQ-018 SHALL drive result_ready_o = !(table[result_id_i].valid && table[result_id_i].wb && result_we_i) || wb_ready_i.
REQ-019 SHALL, on result handshake for a valid entry with wb=1 and result_we_i=1: drive wb_valid_o=1 with wb_rd_o=result_rd_i and wb_data_o=result_data_i combinationally in the same cycle.
REQ-020 SHALL, on result handshake for a valid entry with wb=0 or result_we_i=0: produce no write-back.
REQ-021 SHALL clear table[result_id_i].valid on every result handshake to a valid entry.
REQ-022 SHALL, for a result arriving at an invalid entry: assert result_ready_o=1, drop the result, and pulse protocol_err_o for one cycle.
REQ-023 SHALL, when allocate (REQ-015) and free (REQ-021) occur in the same cycle on different ids, perform both.
REQ-024 SHALL, when a result frees the last-full slot, raise instr_ready_o on the next cycle.
REQ-025 SHALL never select the id held in REQ for a new allocation before the REQ handshake completes.

Reset
REQ-026 SHALL, while rst_i=1 at a clock edge: state=IDLE, all table valid/wb=0, captured registers=0.
REQ-027 SHALL hold all outputs at 0 during reset, except instr_ready_o and result_ready_o, which follow their equations.
REQ-028 SHALL, on reset mid-REQ: drop issue_valid_o the cycle after reset is sampled, and lose in-flight ids silently.

Structure
REQ-029 SHALL place the issue request and response and result structs and the table-entry typedef in the shared package cvxif_instr_pkg.
REQ-030 SHALL implement the outstanding table, with lowest-free allocation and the full flag, as sub-module cvxif_id_table.

Verification
REQ-031 SHALL verify: instr 32'h0000002B, accept=1, writeback=1 -> accepted_o pulse, id=0; then result id0, data 32'hDEADBEEF, rd=5, we=1 -> wb_valid_o with rd=5, data=32'hDEADBEEF.
REQ-032 SHALL verify: issue_accept_i=0 -> illegal_o pulse, no table entry; the next instr gets id=0 again.
REQ-033 SHALL verify: 4 accepted issues (IdWidth=2) -> instr_ready_o=0; result id2 -> next instr gets id2.
REQ-034 SHALL verify: issue_ready_i low for 3 cycles -> issue_valid_o=1 with instr, id and rs unchanged throughout.
REQ-035 SHALL verify: result for id3 while no entry is outstanding -> protocol_err_o=1 for 1 cycle, wb_valid_o=0.
REQ-036 SHALL verify: wb_ready_i=0 with a pending writeback result -> result_ready_o=0 until wb_ready_i=1; a reset in REQ gives issue_valid_o=0 the next cycle.
